// File: rtl/axis_ready_sink.sv
// AXI4-Stream sink: programmable TREADY policy plus beat/checksum/stall statistics.
// Optional sequence checker is built when AXIS_READY_SINK_SEQ_CHECK_EN is defined.
module axis_ready_sink #(
  parameter int DATA_W = 8,
  parameter int TIME_W = 8,
  parameter int CNT_W  = 32
) (
  input  logic              aclk,
  input  logic              aresetn,
  input  logic [DATA_W-1:0] s_axis_tdata,
  input  logic              s_axis_tvalid,
  output logic              s_axis_tready,
  input  logic              cfg_en,
  input  logic [1:0]        cfg_policy,
  input  logic [TIME_W-1:0] cfg_low_time,
  input  logic [TIME_W-1:0] cfg_high_time,
  input  logic [TIME_W-1:0] cfg_events,
  output logic [CNT_W-1:0]  beat_cnt,
  output logic [DATA_W-1:0] checksum,
  output logic [DATA_W-1:0] last_data,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  seq_err_cnt
);

  typedef enum logic [1:0] {S_WAIT, S_LOW, S_HIGH} state_t;

  localparam logic [1:0] P_SINGLE = 2'd1;
  localparam logic [1:0] P_EVENTS = 2'd2;
  localparam logic [1:0] P_AV_OSC = 2'd3;

  state_t            state;
  state_t            idle_state;
  logic [TIME_W-1:0] cnt;
  logic [TIME_W-1:0] high_load;
  logic [1:0]        pol;
  logic              hs;
  logic              low_skip;
  logic              low_done;
  logic              high_done;
  logic              high_tick;

  assign hs         = s_axis_tvalid & s_axis_tready;
  assign low_skip   = (cfg_low_time == '0);
  assign idle_state = (cfg_policy == P_AV_OSC) ? S_WAIT : S_LOW;

  // cnt==0 in S_LOW means the phase was entered by reset/disable and is loaded on its first edge
  always_comb begin
    case (cfg_policy)
      P_SINGLE: high_load = TIME_W'(1);
      P_EVENTS: high_load = (cfg_events == '0) ? TIME_W'(1) : cfg_events;
      default:  high_load = (cfg_high_time == '0) ? TIME_W'(1) : cfg_high_time;
    endcase
    low_done = (cnt == '0) ? (cfg_low_time <= TIME_W'(1)) : (cnt == TIME_W'(1));
    case (pol)
      P_SINGLE: begin
        high_done = hs;
        high_tick = 1'b0;
      end
      P_EVENTS: begin
        high_done = hs && (cnt <= TIME_W'(1));
        high_tick = hs;
      end
      default: begin
        high_done = (cnt <= TIME_W'(1));
        high_tick = 1'b1;
      end
    endcase
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state         <= idle_state;
      cnt           <= '0;
      pol           <= cfg_policy;
      s_axis_tready <= 1'b0;
    end else if (!cfg_en) begin
      state         <= idle_state;
      cnt           <= '0;
      s_axis_tready <= 1'b0;
    end else begin
      case (state)
        S_WAIT: begin
          if (s_axis_tvalid) begin
            if (low_skip) begin
              state         <= S_HIGH;
              cnt           <= high_load;
              pol           <= cfg_policy;
              s_axis_tready <= 1'b1;
            end else begin
              state <= S_LOW;
              cnt   <= cfg_low_time;
            end
          end
        end
        S_LOW: begin
          if (low_done) begin
            state         <= S_HIGH;
            cnt           <= high_load;
            pol           <= cfg_policy;
            s_axis_tready <= 1'b1;
          end else begin
            cnt <= ((cnt == '0) ? cfg_low_time : cnt) - TIME_W'(1);
          end
        end
        S_HIGH: begin
          if (high_done) begin
            if (cfg_policy == P_AV_OSC) begin
              state         <= S_WAIT;
              cnt           <= '0;
              s_axis_tready <= 1'b0;
            end else if (low_skip) begin
              cnt <= high_load;
              pol <= cfg_policy;
            end else begin
              state         <= S_LOW;
              cnt           <= cfg_low_time;
              s_axis_tready <= 1'b0;
            end
          end else if (high_tick) begin
            cnt <= cnt - TIME_W'(1);
          end
        end
        default: begin
          state         <= idle_state;
          cnt           <= '0;
          s_axis_tready <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      beat_cnt  <= '0;
      checksum  <= '0;
      last_data <= '0;
      stall_cnt <= '0;
    end else begin
      if (hs) begin
        beat_cnt  <= beat_cnt + CNT_W'(1);
        checksum  <= checksum + s_axis_tdata;
        last_data <= s_axis_tdata;
      end
      if (s_axis_tvalid && !s_axis_tready && (stall_cnt != '1))
        stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

`ifdef AXIS_READY_SINK_SEQ_CHECK_EN
  logic [DATA_W-1:0] exp_byte;

  // A mismatch resyncs to the received byte so one gap counts as a single error
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      exp_byte    <= '0;
      seq_err_cnt <= '0;
    end else if (hs) begin
      if ((s_axis_tdata != exp_byte) && (seq_err_cnt != '1))
        seq_err_cnt <= seq_err_cnt + CNT_W'(1);
      exp_byte <= s_axis_tdata + DATA_W'(1);
    end
  end
`else
  assign seq_err_cnt = '0;
`endif

endmodule
